// File: rtl/ysyx_25060170_ifu_fetch_pkg.sv
// Shared constants for the IFU fetch stage: reset PC, data widths, FSM encodings.
// No logic here; the macro block is the single place those values are defined.
// The package re-exports them as typed localparams and an enum for the RTL.
`ifndef YSYX_25060170_DEFINE_V
`define YSYX_25060170_DEFINE_V
`define YSYX_25060170_PC_W      32
`define YSYX_25060170_INST_W    32
`define YSYX_25060170_RESET_PC  32'h8000_0000
`define YSYX_25060170_ST_IDLE   2'd0
`define YSYX_25060170_ST_REQ    2'd1
`define YSYX_25060170_ST_WAIT   2'd2
`define YSYX_25060170_ST_HOLD   2'd3
`endif

package ysyx_25060170_ifu_fetch_pkg;

  localparam int PC_W   = `YSYX_25060170_PC_W;
  localparam int INST_W = `YSYX_25060170_INST_W;

  localparam logic [PC_W-1:0] RESET_PC = `YSYX_25060170_RESET_PC;

  typedef enum logic [1:0] {
    ST_IDLE = `YSYX_25060170_ST_IDLE,
    ST_REQ  = `YSYX_25060170_ST_REQ,
    ST_WAIT = `YSYX_25060170_ST_WAIT,
    ST_HOLD = `YSYX_25060170_ST_HOLD
  } fetch_state_e;

  // Fetch addresses are always word aligned; low two bits are dropped.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
    return {pc[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ysyx_25060170_ifu_fetch.sv
// Purpose: instruction fetch FSM; one outstanding imem request, result held toward IF/ID.
// Latency: request the cycle after entering REQ; out_valid the cycle after imem_rsp_valid.
// Backpressure: out_ready=0 holds out_inst/out_pc/imem_req_addr stable; no new request.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   redirect_valid, redirect_pc   single-cycle flush to a new PC (low 2 bits ignored)
//   imem_req_valid/ready/addr     request channel to instruction memory
//   imem_rsp_valid/data           response channel (one response per accepted request)
//   out_valid/ready/inst/pc       fetched instruction toward the IF/ID register
module ysyx_25060170_ifu_fetch
  import ysyx_25060170_ifu_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [PC_W-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [PC_W-1:0]   out_pc
);

  fetch_state_e      state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              kill_q, kill_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [PC_W-1:0]   opc_q, opc_d;
  logic [PC_W-1:0]   redirect_tgt;

  assign redirect_tgt = align_pc(redirect_pc);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      kill_q  <= 1'b0;
      inst_q  <= '0;
      opc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      inst_q  <= inst_d;
      opc_q   <= opc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    kill_d  = kill_q;
    inst_d  = inst_q;
    opc_d   = opc_q;
    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
        if (redirect_valid) pc_d = redirect_tgt;
      end
      ST_REQ: begin
        // An unaccepted address may change freely; once accepted under a
        // redirect, the in-flight response belongs to the old path.
        if (redirect_valid) pc_d = redirect_tgt;
        if (imem_req_ready) begin
          state_d = ST_WAIT;
          kill_d  = redirect_valid;
        end
      end
      ST_WAIT: begin
        if (redirect_valid) begin
          pc_d   = redirect_tgt;
          kill_d = 1'b1;
        end
        if (imem_rsp_valid) begin
          if (redirect_valid || kill_q) begin
            kill_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            inst_d  = imem_rsp_data;
            opc_d   = pc_q;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        // Redirect wins over a simultaneous handshake: no pc+4.
        if (redirect_valid) begin
          pc_d    = redirect_tgt;
          state_d = ST_REQ;
        end else if (out_ready) begin
          pc_d    = pc_q + PC_W'(4);
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pure state decodes: nothing from out_ready reaches out_valid combinationally.
  assign imem_req_valid = (state_q == ST_REQ);
  assign imem_req_addr  = pc_q;
  assign out_valid      = (state_q == ST_HOLD);
  assign out_inst       = inst_q;
  assign out_pc         = opc_q;

endmodule

// File: doc/ysyx_25060170_ifu_fetch.md
YSYX_25060170_IFU_FETCH -- requirements
Module: ysyx_25060170_ifu_fetch

Interface
REQ-001 clk  input  1  clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 redirect_valid  input  1  flush/redirect request from ID/EX/LS; single-cycle pulse.
REQ-004 redirect_pc  input  32  new fetch PC; bits [1:0] forced to 0 internally.
REQ-005 imem_req_valid  output  1  instruction-memory request valid.
REQ-006 imem_req_ready  input  1  memory accepts request this cycle.
REQ-007 imem_req_addr  output  32  fetch address; word aligned.
REQ-008 imem_rsp_valid  input  1  response data valid; never precedes acceptance of its request.
REQ-009 imem_rsp_data  input  32  instruction word.
REQ-010 out_valid  output  1  fetched instruction valid toward IF/ID register.
REQ-011 out_ready  input  1  IF/ID register accepts this cycle (0 = decode stall).
REQ-012 out_inst  output  32  instruction word.
REQ-013 out_pc  output  32  PC of out_inst.

Function
REQ-014 States: IDLE, REQ, WAIT, HOLD; exactly one outstanding imem request at any time.
REQ-015 IDLE: entered only from reset; next cycle unconditionally REQ.
REQ-016 REQ: imem_req_valid=1, imem_req_addr=pc; on imem_req_ready=1 -> WAIT.
REQ-017 WAIT: on imem_rsp_valid=1 and kill=0, capture data and pc into out_inst/out_pc, -> HOLD.
REQ-018 HOLD: out_valid=1; on out_ready=1, pc <= pc+4 and -> REQ (next request issued the following cycle).
REQ-019 out_inst, out_pc, and imem_req_addr SHALL stay stable while out_valid=1 and out_ready=0 (stall).
REQ-020 pc+4 SHALL wrap modulo 2^32 (0xFFFFFFFC -> 0x00000000).
REQ-021 Redirect in REQ with imem_req_ready=0: pc <= redirect_pc, stay REQ; the bus permits an unaccepted address to change.
REQ-022 Redirect in REQ with imem_req_ready=1: pc <= redirect_pc, set kill, -> WAIT.
REQ-023 Redirect in WAIT: pc <= redirect_pc, set kill; if imem_rsp_valid is high in the same cycle, drop the response and -> REQ.
REQ-024 WAIT with kill=1: drop the response on imem_rsp_valid, clear kill, -> REQ; out_valid stays 0.
REQ-025 Redirect in HOLD: out_valid drops next cycle, buffered instruction discarded, pc <= redirect_pc, -> REQ; redirect wins over a simultaneous out_ready=1 (no pc+4).
REQ-026 Redirect in IDLE: pc <= redirect_pc, -> REQ.
REQ-027 Repeated redirects SHALL leave only the last redirect_pc in effect; kill is one bit and never counts.
REQ-028 out_valid and imem_req_valid are registered state decodes; no combinational path from out_ready to out_valid.

Reset
REQ-029 On rst: state=IDLE, pc=0x80000000, kill=0, out_valid=0, out_inst=0x00000000, out_pc=0x00000000, imem_req_valid=0.
REQ-030 rst SHALL take priority over redirect and all handshakes; reset during WAIT abandons the outstanding response, and the memory side is reset concurrently.

Structure
REQ-031 Reset PC (0x80000000), state encodings, and the 32-bit PC/INST width macros SHALL live in define.v.
REQ-032 Single module; no sub-module. The FSM and pc register are inline.

Verification
REQ-033 Reset, zero-wait memory (ready=1, rsp one cycle after acceptance), out_ready=1 -> addresses 0x80000000, 0x80000004, 0x80000008 in order; out_pc matches each issued address.
REQ-034 out_ready=0 for 5 cycles in HOLD with inst 0x00000513 -> out_valid=1, out_inst/out_pc unchanged, no new imem request issued.
REQ-035 Redirect to 0x80001000 during WAIT, rsp arrives 3 cycles later -> that response is dropped, next request addr=0x80001000, out_valid never shows the stale instruction.
REQ-036 Redirect to 0x80000200 in HOLD in the same cycle as out_ready=1 -> no transfer-driven pc+4, next request addr=0x80000200.
REQ-037 Redirect 0x80000103 in REQ with req_ready=0 -> imem_req_addr becomes 0x80000100 the next cycle.
REQ-038 pc=0xFFFFFFFC accepted downstream -> next imem_req_addr=0x00000000.
